lc3_mem_seq: RTL and testbench

Multi-cycle sequencer for LC-3 address-generation and memory instructions: LD, LDI, LDR, ST, STI, STR, LEA and JSR (PC-relative form). It sits between the decode stage, the effective-address adder (EAB), the register file and the memory port. For one instruction it drives the EAB select lines, captures the computed address, and runs one or two memory handshakes. It reports completion with a load result or a jump target.

---
 rtl/lc3_mem_seq.sv | 164 ++++++++++++++++
 tb/tb_lc3_mem_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_seq.sv
// rtl/lc3_mem_seq.sv - LC-3 sequencer for LD/LDI/LDR/ST/STI/STR/LEA/JSR address generation and memory access
module lc3_mem_seq #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] ir,
   input  logic [15:0] sr_data,
   input  logic [15:0] eab_out,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        sel_eab1,
   output logic [1:0]  sel_eab2,
   output logic [2:0]  base_r,
   output logic [2:0]  sr_sel,
   output logic [2:0]  dr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] result,
   output logic        reg_we,
   output logic        pc_load
);

   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, EA, IND, READ, WRITE, DONE} state_t;
   typedef enum logic [3:0] {K_ILL, K_LD, K_LDI, K_LDR, K_LEA, K_ST, K_STI, K_STR, K_JSR} kind_t;

   // JSR is only legal in its PC-relative form (bit 11 set); JSRR falls through to illegal.
   function automatic kind_t decode(input logic [15:0] w);
      casez (w)
         16'b0010_????_????_????: return K_LD;
         16'b1010_????_????_????: return K_LDI;
         16'b0110_????_????_????: return K_LDR;
         16'b1110_????_????_????: return K_LEA;
         16'b0011_????_????_????: return K_ST;
         16'b1011_????_????_????: return K_STI;
         16'b0111_????_????_????: return K_STR;
         16'b0100_1???_????_????: return K_JSR;
         default:                 return K_ILL;
      endcase
   endfunction

   state_t         state, stateNext;
   logic [15:0]    irQ, mar, resultQ;
   logic           errQ;
   logic [WW-1:0]  waitCnt;
   kind_t          kind;
   logic           memState, timeoutHit;

   assign kind       = decode(irQ);
   assign memState   = (state == IND) || (state == READ) || (state == WRITE);
   assign timeoutHit = memState && (waitCnt == LIMIT) && !mem_ack;

   always_comb begin
      stateNext = state;
      sel_eab1  = 1'b0;
      sel_eab2  = 2'b00;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      case (state)
         IDLE: begin
            if (start) stateNext = (decode(ir) == K_ILL) ? DONE : EA;
         end
         EA: begin
            case (kind)
               K_LDR, K_STR: begin
                  sel_eab1 = 1'b1;
                  sel_eab2 = 2'b01;
               end
               K_JSR:   sel_eab2 = 2'b11;
               default: sel_eab2 = 2'b10;
            endcase
            case (kind)
               K_LDI, K_STI: stateNext = IND;
               K_LD, K_LDR:  stateNext = READ;
               K_ST, K_STR:  stateNext = WRITE;
               default:      stateNext = DONE;
            endcase
         end
         IND: begin
            mem_req  = 1'b1;
            mem_addr = mar;
            if (mem_ack)         stateNext = (kind == K_LDI) ? READ : WRITE;
            else if (timeoutHit) stateNext = DONE;
         end
         READ: begin
            mem_req  = 1'b1;
            mem_addr = mar;
            if (mem_ack || timeoutHit) stateNext = DONE;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = mar;
            mem_wdata = sr_data;
            if (mem_ack || timeoutHit) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         irQ     <= 16'h0000;
         mar     <= 16'h0000;
         resultQ <= 16'h0000;
         errQ    <= 1'b0;
         waitCnt <= '0;
      end else begin
         state <= stateNext;
         // Every state change re-arms the wait counter, so each memory phase gets a full budget.
         if (stateNext != state)          waitCnt <= '0;
         else if (memState && !mem_ack)   waitCnt <= waitCnt + WW'(1);
         case (state)
            IDLE: begin
               if (start) begin
                  irQ  <= ir;
                  errQ <= (decode(ir) == K_ILL);
               end
            end
            EA: begin
               mar <= eab_out;
               if (kind == K_LEA || kind == K_JSR) resultQ <= eab_out;
            end
            IND: begin
               if (mem_ack)         mar  <= mem_rdata;
               else if (timeoutHit) errQ <= 1'b1;
            end
            READ: begin
               if (mem_ack)         resultQ <= mem_rdata;
               else if (timeoutHit) errQ    <= 1'b1;
            end
            WRITE: begin
               if (timeoutHit) errQ <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign err     = done && errQ;
   assign reg_we  = done && !errQ &&
                    (kind == K_LD || kind == K_LDI || kind == K_LDR || kind == K_LEA);
   assign pc_load = done && !errQ && (kind == K_JSR);
   assign result  = resultQ;
   assign base_r  = irQ[8:6];
   assign sr_sel  = irQ[11:9];
   assign dr      = irQ[11:9];

endmodule

// File: tb/tb_lc3_mem_seq.sv
// tb/tb_lc3_mem_seq.sv - scoreboard bench for lc3_mem_seq with EAB, register-file and memory models
module tb_lc3_mem_seq;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0;
   logic [15:0] ir = 16'h0000, mem_rdata = 16'h0000;
   logic [15:0] sr_data, eab_out;
   logic        sel_eab1, mem_req, mem_we, busy, done, err, reg_we, pc_load;
   logic [1:0]  sel_eab2;
   logic [2:0]  base_r, sr_sel, dr;
   logic [15:0] mem_addr, mem_wdata, result;

   lc3_mem_seq #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .sr_data(sr_data),
      .eab_out(eab_out), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .sel_eab1(sel_eab1), .sel_eab2(sel_eab2), .base_r(base_r), .sr_sel(sr_sel),
      .dr(dr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .result(result),
      .reg_we(reg_we), .pc_load(pc_load)
   );

   always #5 clk = ~clk;

   // Datapath surroundings: PC, register file, EAB adder and memory
   logic [15:0] pc = 16'h0000;
   logic [15:0] regs [8];
   logic [15:0] mem [65536];
   logic [15:0] refMem [65536];
   logic [15:0] offSel;

   always_comb begin
      offSel = 16'h0000;
      case (sel_eab2)
         2'b01:   offSel = 16'($signed(ir[5:0]));
         2'b10:   offSel = 16'($signed(ir[8:0]));
         2'b11:   offSel = 16'($signed(ir[10:0]));
         default: offSel = 16'h0000;
      endcase
   end
   assign eab_out = (sel_eab1 ? regs[base_r] : pc) + offSel;
   assign sr_data = regs[sr_sel];

   typedef struct {
      logic [15:0] result;
      logic        err, regWe, pcLoad, s1;
      logic [1:0]  s2;
      logic [2:0]  dr;
      int          eaCycles, reqCycles, doneCyc;
   } exp_t;

   exp_t        expQ[$];
   int          waitQ[$];
   int          vectors = 0, miscompares = 0, cyc = 0;
   logic [15:0] lastRes = 16'h0000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name, input string detail);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
   endtask

   function automatic int accCycles(input int w);
      return (w >= TIMEOUT) ? TIMEOUT : w + 1;
   endfunction

   // Reference: architectural effect of one instruction given the chosen ack delays
   task automatic model(input logic [15:0] w, input int w1, input int w2, output exp_t e);
      logic [15:0] addr;
      logic [3:0]  op;
      bit          isMem, isInd, isLoad, ok;
      int          reqs, nextW;
      op = w[15:12];
      e.result = lastRes; e.err = 1'b0; e.regWe = 1'b0; e.pcLoad = 1'b0;
      e.s1 = 1'b0; e.s2 = 2'b00; e.dr = w[11:9]; e.eaCycles = 1;
      addr = 16'h0000; reqs = 0; ok = 1;
      isMem  = (op inside {4'h2, 4'hA, 4'h3, 4'hB, 4'h6, 4'h7});
      isInd  = (op inside {4'hA, 4'hB});
      isLoad = (op inside {4'h2, 4'hA, 4'h6});
      case (op)
         4'hE: begin e.s2 = 2'b10; e.result = pc + 16'($signed(w[8:0])); e.regWe = 1'b1; end
         4'h4: begin
            if (w[11]) begin
               e.s2 = 2'b11; e.result = pc + 16'($signed(w[10:0])); e.pcLoad = 1'b1;
            end else e.err = 1'b1;
         end
         4'h2, 4'hA, 4'h3, 4'hB: begin e.s2 = 2'b10; addr = pc + 16'($signed(w[8:0])); end
         4'h6, 4'h7: begin e.s1 = 1'b1; e.s2 = 2'b01; addr = regs[w[8:6]] + 16'($signed(w[5:0])); end
         default: e.err = 1'b1;
      endcase
      if (e.err) begin
         e.eaCycles = 0; e.reqCycles = 0; e.doneCyc = 1;
      end else begin
         if (isMem) begin
            nextW = w1;
            if (isInd) begin
               waitQ.push_back(w1);
               reqs += accCycles(w1);
               if (w1 >= TIMEOUT) ok = 0; else addr = refMem[addr];
               nextW = w2;
            end
            if (ok) begin
               waitQ.push_back(nextW);
               reqs += accCycles(nextW);
               if (nextW >= TIMEOUT) ok = 0;
               else if (isLoad) e.result = refMem[addr];
               else refMem[addr] = regs[w[11:9]];
            end
            if (!ok) e.err = 1'b1;
            else if (isLoad) e.regWe = 1'b1;
         end
         e.reqCycles = reqs;
         e.doneCyc = 2 + reqs;
      end
      lastRes = e.result;
   endtask

   task automatic waitIdle();
      int guard = 0;
      while (busy && guard < 200) begin @(negedge clk); guard++; end
      if (busy) fail("idle_wait", "busy never dropped");
   endtask

   // Called on a falling edge; start is sampled on the next rising edge
   task automatic issue(input logic [15:0] instr, input int w1, input int w2, input bit track);
      exp_t e;
      waitIdle();
      if (track) begin
         model(instr, w1, w2, e);
         e.doneCyc = e.doneCyc + cyc;
         expQ.push_back(e);
      end else waitQ.push_back(w1);
      ir = instr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((expQ.size() != 0 || busy) && guard < 1000) begin @(negedge clk); guard++; end
      if (guard >= 1000) begin fail("drain", "expected completions never arrived"); expQ.delete(); end
   endtask

   // Memory responder: per-access delay comes from waitQ, as chosen by the stimulus
   int          curWait = 0, waitCnt = 0;
   bit          inAcc = 0;
   logic [15:0] addr0, wdata0;
   logic        we0;
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (mem_req) begin
         if (!inAcc) begin
            inAcc = 1; waitCnt = 0; addr0 = mem_addr; we0 = mem_we; wdata0 = mem_wdata;
            if (waitQ.size() == 0) begin
               fail("unexpected_req", $sformatf("mem_req with addr %h", mem_addr));
               curWait = 0;
            end else curWait = waitQ.pop_front();
         end else begin
            check("addr_stable", mem_addr, addr0);
            check("we_stable", mem_we, we0);
            check("wdata_stable", mem_wdata, wdata0);
         end
         if (waitCnt == curWait) begin
            mem_ack = 1'b1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem[mem_addr];
            inAcc = 0;
         end else waitCnt++;
      end else inAcc = 0;
   end

   // Monitor: pops the scoreboard on every done pulse
   int          reqCnt = 0, eaCnt = 0;
   logic        s1Seen = 1'b0;
   logic [1:0]  s2Seen = 2'b00;
   exp_t        monE;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reqCnt = 0; eaCnt = 0; s1Seen = 1'b0; s2Seen = 2'b00;
      end else begin
         if (mem_req) reqCnt++;
         if (sel_eab1 || sel_eab2 != 2'b00) begin eaCnt++; s1Seen = sel_eab1; s2Seen = sel_eab2; end
         if (done) begin
            if (expQ.size() == 0) fail("unexpected_done", $sformatf("result %h err %b", result, err));
            else begin
               monE = expQ.pop_front();
               check("done_cycle", cyc, monE.doneCyc);
               check("result", result, monE.result);
               check("err", err, monE.err);
               check("reg_we", reg_we, monE.regWe);
               check("pc_load", pc_load, monE.pcLoad);
               check("dr", dr, monE.dr);
               check("req_cycles", reqCnt, monE.reqCycles);
               check("ea_cycles", eaCnt, monE.eaCycles);
               check("sel_eab1", s1Seen, monE.s1);
               check("sel_eab2", s2Seen, monE.s2);
            end
            reqCnt = 0; eaCnt = 0; s1Seen = 1'b0; s2Seen = 2'b00;
         end
      end
   end

   function automatic logic [15:0] randInstr();
      logic [3:0]  legal [8];
      logic [3:0]  bad [8];
      logic [15:0] w;
      legal = '{4'h2, 4'hA, 4'h3, 4'hB, 4'hE, 4'h6, 4'h7, 4'h4};
      bad   = '{4'h0, 4'h1, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'hF};
      w = 16'($urandom());
      if ($urandom_range(0, 9) == 0) w[15:12] = bad[$urandom_range(0, 7)];
      else begin
         w[15:12] = legal[$urandom_range(0, 7)];
         if (w[15:12] == 4'h4) w[11] = ($urandom_range(0, 7) != 0);
      end
      return w;
   endfunction

   function automatic int randWait();
      int r = $urandom_range(0, 19);
      if (r == 0) return TIMEOUT;
      if (r == 1) return TIMEOUT - 1;
      return $urandom_range(0, 3);
   endfunction

   int diffs;
   initial begin
      for (int r = 0; r < 8; r++) regs[r] = 16'($urandom());
      for (int a = 0; a < 65536; a++) begin mem[a] = 16'($urandom()); refMem[a] = mem[a]; end

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);        check("rst_done", done, 0);
      check("rst_err", err, 0);          check("rst_reg_we", reg_we, 0);
      check("rst_pc_load", pc_load, 0);  check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);    check("rst_sel_eab1", sel_eab1, 0);
      check("rst_sel_eab2", sel_eab2, 0); check("rst_result", result, 0);
      check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
      check("rst_dr", dr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      pc = 16'h3000;
      issue(16'hE1FF, 0, 0, 1); drain();
      check("lea_result", result, 16'h2FFF);

      regs[2] = 16'h4000; mem[16'h4002] = 16'hBEEF; refMem[16'h4002] = 16'hBEEF;
      issue(16'h6A82, 2, 0, 1); drain();
      check("ldr_result", result, 16'hBEEF);

      pc = 16'h3001; regs[3] = 16'h1234; mem[16'h3006] = 16'h5000; refMem[16'h3006] = 16'h5000;
      issue(16'hB605, 0, 0, 1); drain();
      check("sti_mem", mem[16'h5000], 16'h1234);

      pc = 16'h3000;
      issue(16'h4FFF, 0, 0, 1); drain();
      check("jsr_result", result, 16'h2FFF);

      pc = 16'h3100;
      issue(16'hD000, 0, 0, 1);
      issue(16'h2402, 0, 0, 1); drain();

      issue(16'h2005, TIMEOUT, 0, 1); drain();
      issue(16'h2005, TIMEOUT - 1, 0, 1); drain();
      issue(16'hA005, 1, TIMEOUT, 1); drain();
      issue(16'h7E3F, TIMEOUT, 0, 1); drain();

      // Reset in the middle of a stalled read
      issue(16'h2205, TIMEOUT, 0, 0);
      repeat (4) @(negedge clk);
      check("pre_rst_req", mem_req, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_req_drop", mem_req, 0);
      check("rst_busy_drop", busy, 0);
      check("rst_result_clr", result, 0);
      lastRes = 16'h0000;
      waitQ.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      pc = 16'h1234;
      issue(16'hE010, 0, 0, 1); drain();

      for (int n = 0; n < 250; n++) begin
         waitIdle();
         pc = 16'($urandom());
         for (int r = 0; r < 8; r++) regs[r] = 16'($urandom());
         issue(randInstr(), randWait(), randWait(), 1);
      end
      drain();

      diffs = 0;
      for (int a = 0; a < 65536; a++) if (mem[a] !== refMem[a]) diffs++;
      check("mem_image_diffs", diffs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
